// File: rtl/act_row_ctrl.sv
// act_row_ctrl: row-level sequencer for the activation fetch path.
// Sparse mode fetches a flag word per row and streams the positions of its set
// bits lowest-first. Dense mode streams every position of every row without
// touching the flag memory. Every output is decoded from registered state.
module act_row_ctrl #(
  parameter int IF_WIDTH        = 16,
  parameter int ACT_INDEX_WIDTH = 4,
  parameter int ROW_ADDR_WIDTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       mode,
  input  logic [ROW_ADDR_WIDTH:0]    row_total,
  output logic                       flag_rd_req,
  output logic [ROW_ADDR_WIDTH-1:0]  flag_rd_addr,
  input  logic                       flag_rd_valid,
  input  logic [IF_WIDTH-1:0]        flag_rd_data,
  output logic                       act_valid,
  input  logic                       act_ready,
  output logic [ACT_INDEX_WIDTH-1:0] act_index,
  output logic [ROW_ADDR_WIDTH-1:0]  row_index,
  output logic [ACT_INDEX_WIDTH:0]   row_val_num,
  output logic                       row_cal_done,
  output logic                       zero_row,
  output logic                       all_done,
  output logic                       busy
);

  localparam int CNT_W = ACT_INDEX_WIDTH + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(IF_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_STREAM,
    S_ROW_END,
    S_FINISH
  } state_t;

  state_t                      state_q, state_d;
  logic                        mode_q, mode_d;
  logic [ROW_ADDR_WIDTH:0]     row_total_q, row_total_d;
  logic [ROW_ADDR_WIDTH-1:0]   row_index_q, row_index_d;
  logic [CNT_W-1:0]            row_val_num_q, row_val_num_d;
  logic [CNT_W-1:0]            remain_q, remain_d;
  logic [IF_WIDTH-1:0]         flag_reg_q, flag_reg_d;
  logic [ACT_INDEX_WIDTH-1:0]  pos_q, pos_d;
  logic [CNT_W-1:0]            flag_cnt;

  // Number of set bits; wide enough that an all-ones word counts IF_WIDTH.
  function automatic logic [CNT_W-1:0] popcount(input logic [IF_WIDTH-1:0] w);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < IF_WIDTH; i++) begin
      cnt = cnt + CNT_W'(w[i]);
    end
    return cnt;
  endfunction

  // Position of the lowest set bit; zero for an empty word.
  function automatic logic [ACT_INDEX_WIDTH-1:0] lowest_set(input logic [IF_WIDTH-1:0] w);
    logic [ACT_INDEX_WIDTH-1:0] idx;
    idx = '0;
    for (int i = IF_WIDTH - 1; i >= 0; i--) begin
      if (w[i]) idx = ACT_INDEX_WIDTH'(i);
    end
    return idx;
  endfunction

  assign flag_cnt = popcount(flag_rd_data);

  // Next-state and datapath-register update for the row sequencer.
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    row_total_d   = row_total_q;
    row_index_d   = row_index_q;
    row_val_num_d = row_val_num_q;
    remain_d      = remain_q;
    flag_reg_d    = flag_reg_q;
    pos_d         = pos_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d      = mode;
          row_total_d = row_total;
          row_index_d = '0;
          if (row_total == '0) begin
            state_d = S_FINISH;
          end else if (mode) begin
            state_d       = S_STREAM;
            row_val_num_d = FULL_CNT;
            remain_d      = FULL_CNT;
            pos_d         = '0;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (flag_rd_valid) begin
          flag_reg_d    = flag_rd_data;
          row_val_num_d = flag_cnt;
          remain_d      = flag_cnt;
          state_d       = (flag_cnt == '0) ? S_ROW_END : S_STREAM;
        end
      end
      S_STREAM: begin
        if (act_ready) begin
          if (mode_q) begin
            pos_d = pos_q + ACT_INDEX_WIDTH'(1);
          end else begin
            // Clearing the lowest set bit retires the index just accepted.
            flag_reg_d = flag_reg_q & (flag_reg_q - IF_WIDTH'(1));
          end
          remain_d = remain_q - CNT_W'(1);
          if (remain_q == CNT_W'(1)) state_d = S_ROW_END;
        end
      end
      S_ROW_END: begin
        if ({1'b0, row_index_q} == row_total_q - (ROW_ADDR_WIDTH + 1)'(1)) begin
          state_d = S_FINISH;
        end else begin
          row_index_d = row_index_q + ROW_ADDR_WIDTH'(1);
          if (mode_q) begin
            state_d       = S_STREAM;
            row_val_num_d = FULL_CNT;
            remain_d      = FULL_CNT;
            pos_d         = '0;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state and row registers; reset aborts any tile in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      mode_q        <= 1'b0;
      row_total_q   <= '0;
      row_index_q   <= '0;
      row_val_num_q <= '0;
      remain_q      <= '0;
      flag_reg_q    <= '0;
      pos_q         <= '0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      row_total_q   <= row_total_d;
      row_index_q   <= row_index_d;
      row_val_num_q <= row_val_num_d;
      remain_q      <= remain_d;
      flag_reg_q    <= flag_reg_d;
      pos_q         <= pos_d;
    end
  end

  // Moore output decode; act_valid never depends on act_ready.
  always_comb begin
    flag_rd_req  = (state_q == S_REQ);
    flag_rd_addr = row_index_q;
    act_valid    = (state_q == S_STREAM);
    act_index    = '0;
    if (state_q == S_STREAM) begin
      act_index = mode_q ? pos_q : lowest_set(flag_reg_q);
    end
    row_index    = row_index_q;
    row_val_num  = row_val_num_q;
    row_cal_done = (state_q == S_ROW_END);
    zero_row     = (state_q == S_ROW_END) && (row_val_num_q == '0);
    all_done     = (state_q == S_FINISH);
    busy         = (state_q != S_IDLE);
  end

endmodule
